bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Two-master arbiter sharing the single CPU external bus between master 0 (CPU core) and
//  master 1 (debug loader / DMA). Grants one master at a time with round-robin fairness, holds
//  the grant for one whole transaction, routes responses to the owner only, and aborts any
//  transaction the slave leaves unanswered for TIMEOUT cycles.
// PARAMETERS
//  AW       32   address width
//  DW       32   data width
//  TIMEOUT  256  cycles a granted transaction may wait for completion before abort; 0 = never
// PORTS (N = 0,1; one set per master)
//  clk        in   1   clock; all state updates on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  mN_valid   in   1   master request; held with addr/mode/wdata stable until completion
//  mN_mode    in   1   1 = write, 0 = read
//  mN_addr    in   AW  transaction address
//  mN_wdata   in   DW  write data
//  mN_rready  in   1   master ready to accept read data
//  mN_wready  out  1   write done (owner only, one cycle)
//  mN_rvalid  out  1   read data valid (owner only)
//  mN_rdata   out  DW  read data (owner only, else 0)
//  mN_err     out  1   one-cycle pulse: owner's transaction aborted by timeout
//  s_valid    out  1   to slave bus: request valid
//  s_mode     out  1   to slave bus: 1 = write, 0 = read
//  s_addr     out  AW  to slave bus: address
//  s_wdata    out  DW  to slave bus: write data
//  s_rready   out  1   to slave bus: owner's rready
//  s_wready   in   1   from slave: write complete
//  s_rvalid   in   1   from slave: read data valid
//  s_rdata    in   DW  from slave: read data
//  grant      out  2   one-hot owner (bit N = master N); 2'b00 when idle
// BEHAVIOUR
//  - Reset: state IDLE, grant=00, s_valid/s_mode/s_rready=0, s_addr/s_wdata=0, all mN_* outputs 0,
//    err pulses cleared, timeout counter 0, round-robin pointer last=1 (master 0 wins first tie).
//  - FSM IDLE -> OWN0 | OWN1 -> IDLE. grant is a registered decode of state.
//  - IDLE: if exactly one mN_valid, next state OWNN; if both, grant the master != last; update last.
//    Grant registered: request seen at edge N, s_valid=1 in cycle N+1 (1-cycle arbitration latency).
//  - OWNN: s_valid/s_mode/s_addr/s_wdata/s_rready driven combinationally from master N;
//    mN_wready=s_wready, mN_rvalid=s_rvalid, mN_rdata=s_rdata; other master sees 0s.
//  - Completion: write: s_wready=1 while s_mode=1; read: s_rvalid & s_rready both 1.
//    Completion cycle -> IDLE next edge; one idle bubble before next grant (max 1 txn per 2+ cycles).
//  - Owner drops mN_valid before completion: abandoned; IDLE next edge, no err; late slave
//    responses arriving in IDLE are ignored (not forwarded to either master).
//  - Timeout: counter clears on entering OWNN, increments each OWNN cycle without completion;
//    when count reaches TIMEOUT-1 without completion: mN_err pulses 1 cycle (registered, cycle after),
//    state -> IDLE, s_valid drops. Counter width clog2(TIMEOUT+1); TIMEOUT=0 disables logic.
//  - Completion and timeout on the same cycle: completion wins, no err.
//  - s_wready/s_rvalid while IDLE or in wrong mode: ignored.
//  - Reset asserted mid-transaction: immediate return to reset values, s_valid drops asynchronously;
//    no err pulse, no response forwarded.
//  - Non-owner mN_valid waits without limit; round-robin bounds wait to one foreign transaction.
// TESTING
//  1. m0 read 0x100, slave rvalid after 3 cycles with 0xDEADBEEF -> grant=01 one cycle after
//     request, m0_rdata=0xDEADBEEF with m0_rvalid, m1 outputs 0, grant=00 after.
//  2. m0 and m1 request same cycle after reset -> m0 first; both keep requesting -> grant
//     alternates 01,00,10,00,01...
//  3. m1 write 0x200 data 0x12345678, s_wready after 2 cycles -> s_addr/s_wdata match,
//     m1_wready one pulse, m0_wready stays 0.
//  4. TIMEOUT=8, m0 read with silent slave -> m0_err single pulse after 8 owned cycles,
//     s_valid=0, next m1 request granted.
//  5. rst_n low during m1 read in flight -> grant=00, s_valid=0 immediately; late s_rvalid
//     not forwarded; after release m0 wins first tie.
//  6. m0 drops valid mid-read, s_rvalid arrives in IDLE -> no m0_rvalid, no m0_err.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one external bus between two masters with round-robin
// arbitration, whole-transaction ownership, owner-only response routing and an
// optional timeout abort for transactions the slave never answers.
module bus_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  // master 0 (CPU core)
  input  logic          m0_valid,
  input  logic          m0_mode,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_rready,
  output logic          m0_wready,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  // master 1 (debug loader / DMA)
  input  logic          m1_valid,
  input  logic          m1_mode,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_rready,
  output logic          m1_wready,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  // slave bus
  output logic          s_valid,
  output logic          s_mode,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_rready,
  input  logic          s_wready,
  input  logic          s_rvalid,
  input  logic [DW-1:0] s_rdata,
  // current owner, one-hot
  output logic [1:0]    grant
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last;
  logic       w_last_nxt;
  logic [1:0] r_grant;
  logic       r_m0_err;
  logic       r_m1_err;
  logic       w_m0_err_nxt;
  logic       w_m1_err_nxt;
  logic       w_done;
  logic       w_timeout;

  // Owner's transaction completes: write acknowledged, or read handshake.
  assign w_done = s_valid & (s_mode ? s_wready : (s_rvalid & s_rready));

  // Owned-cycle counter; the IDLE cycle between grants rezeroes it.
  generate
    if (TIMEOUT != 0) begin : g_timeout
      logic [CW-1:0] r_cnt;

      // Count cycles spent owning the bus without completion.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  // State, round-robin pointer, grant decode and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_grant  <= 2'b00;
      r_m0_err <= 1'b0;
      r_m1_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_last   <= w_last_nxt;
      r_grant  <= {w_state_nxt == S_OWN1, w_state_nxt == S_OWN0};
      r_m0_err <= w_m0_err_nxt;
      r_m1_err <= w_m1_err_nxt;
    end
  end

  // Arbitration and end-of-ownership decisions; completion beats timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last;
    w_m0_err_nxt = 1'b0;
    w_m1_err_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (m0_valid && m1_valid) begin
          if (r_last) begin
            w_state_nxt = S_OWN0;
            w_last_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_OWN1;
            w_last_nxt  = 1'b1;
          end
        end else if (m0_valid) begin
          w_state_nxt = S_OWN0;
          w_last_nxt  = 1'b0;
        end else if (m1_valid) begin
          w_state_nxt = S_OWN1;
          w_last_nxt  = 1'b1;
        end
      end
      S_OWN0: begin
        if (!m0_valid || w_done) begin
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_state_nxt  = S_IDLE;
          w_m0_err_nxt = 1'b1;
        end
      end
      S_OWN1: begin
        if (!m1_valid || w_done) begin
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_state_nxt  = S_IDLE;
          w_m1_err_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Route the owner onto the slave bus and slave responses back to the owner only.
  always_comb begin
    s_valid   = 1'b0;
    s_mode    = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_rready  = 1'b0;
    m0_wready = 1'b0;
    m0_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_wready = 1'b0;
    m1_rvalid = 1'b0;
    m1_rdata  = '0;
    unique case (r_state)
      S_OWN0: begin
        s_valid   = m0_valid;
        s_mode    = m0_mode;
        s_addr    = m0_addr;
        s_wdata   = m0_wdata;
        s_rready  = m0_rready;
        m0_wready = s_wready;
        m0_rvalid = s_rvalid;
        m0_rdata  = s_rdata;
      end
      S_OWN1: begin
        s_valid   = m1_valid;
        s_mode    = m1_mode;
        s_addr    = m1_addr;
        s_wdata   = m1_wdata;
        s_rready  = m1_rready;
        m1_wready = s_wready;
        m1_rvalid = s_rvalid;
        m1_rdata  = s_rdata;
      end
      default: begin
      end
    endcase
  end

  assign grant  = r_grant;
  assign m0_err = r_m0_err;
  assign m1_err = r_m1_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: random two-master traffic against a random-latency slave,
// every output compared each cycle with a transaction-level model of the arbiter.
module tb_bus_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned TO   = 8;
  localparam int          NCYC = 6000;

  logic          clk;
  logic          rst_n;
  logic          m0_valid, m0_mode, m0_rready, m0_wready, m0_rvalid, m0_err;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_valid, m1_mode, m1_rready, m1_wready, m1_rvalid, m1_err;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          s_valid, s_mode, s_rready, s_wready, s_rvalid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [1:0]    grant;

  bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_mode(m0_mode), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rready(m0_rready), .m0_wready(m0_wready), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_mode(m1_mode), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rready(m1_rready), .m1_wready(m1_wready), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_valid(s_valid), .s_mode(s_mode), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rready(s_rready), .s_wready(s_wready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .grant(grant)
  );

  int checks;
  int failures;

  // Reference model: owner is -1 (nobody) or the master index.
  int owner, last, wcnt;
  int n_owner, n_last, n_wcnt;
  bit err_exp[2];
  bit n_err[2];

  // Master-side transaction state.
  bit            act[2];
  bit            md[2];
  bit            rr[2];
  logic [AW-1:0] ad[2];
  logic [DW-1:0] wd[2];

  // Slave response timing for the current ownership.
  int            scnt, sdelay;
  logic [DW-1:0] srd;

  int n_tie, n_to, n_done, n_ab, n_rst, n_bound;
  int next_rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=0x%0h exp=0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic drive_masters();
    m0_valid = act[0]; m0_mode = md[0]; m0_addr = ad[0]; m0_wdata = wd[0]; m0_rready = rr[0];
    m1_valid = act[1]; m1_mode = md[1]; m1_addr = ad[1]; m1_wdata = wd[1]; m1_rready = rr[1];
  endtask

  task automatic check_outputs();
    logic [1:0]    eg;
    logic          ev, em, er;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    ev = 1'b0; em = 1'b0; er = 1'b0; ea = '0; ew = '0;
    if (owner >= 0) begin
      ev = act[owner]; em = md[owner]; er = rr[owner]; ea = ad[owner]; ew = wd[owner];
    end
    check_eq("grant",     64'(grant),     64'(eg));
    check_eq("s_valid",   64'(s_valid),   64'(ev));
    check_eq("s_mode",    64'(s_mode),    64'(em));
    check_eq("s_rready",  64'(s_rready),  64'(er));
    check_eq("s_addr",    64'(s_addr),    64'(ea));
    check_eq("s_wdata",   64'(s_wdata),   64'(ew));
    check_eq("m0_wready", 64'(m0_wready), 64'((owner == 0) ? s_wready : 1'b0));
    check_eq("m0_rvalid", 64'(m0_rvalid), 64'((owner == 0) ? s_rvalid : 1'b0));
    check_eq("m0_rdata",  64'(m0_rdata),  64'((owner == 0) ? s_rdata : '0));
    check_eq("m1_wready", 64'(m1_wready), 64'((owner == 1) ? s_wready : 1'b0));
    check_eq("m1_rvalid", 64'(m1_rvalid), 64'((owner == 1) ? s_rvalid : 1'b0));
    check_eq("m1_rdata",  64'(m1_rdata),  64'((owner == 1) ? s_rdata : '0));
    check_eq("m0_err",    64'(m0_err),    64'(err_exp[0]));
    check_eq("m1_err",    64'(m1_err),    64'(err_exp[1]));
  endtask

  // Decide the owner for the next cycle from this cycle's requests and responses.
  task automatic model_step();
    bit done;
    n_err[0] = 1'b0;
    n_err[1] = 1'b0;
    n_last   = last;
    n_wcnt   = wcnt;
    n_owner  = owner;
    if (owner < 0) begin
      if (act[0] && act[1]) begin
        n_owner = 1 - last;
        n_tie++;
      end else if (act[0]) begin
        n_owner = 0;
      end else if (act[1]) begin
        n_owner = 1;
      end
      if (n_owner >= 0) begin
        n_last = n_owner;
        n_wcnt = 0;
      end
    end else begin
      done = act[owner] && (md[owner] ? s_wready : (s_rvalid && rr[owner]));
      if (!act[owner]) begin
        n_owner = -1;
        n_ab++;
      end else if (done) begin
        n_owner = -1;
        n_done++;
        if (wcnt == int'(TO) - 1) n_bound++;
        act[owner] = 1'b0;
      end else if (wcnt == int'(TO) - 1) begin
        n_err[owner] = 1'b1;
        n_owner = -1;
        n_to++;
        act[owner] = 1'b0;
      end else begin
        n_wcnt = wcnt + 1;
      end
    end
  endtask

  // Asynchronous reset while a master owns the bus, with a late slave response present.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    s_rvalid = 1'b1;
    s_wready = 1'b1;
    s_rdata  = $urandom;
    #1;
    check_eq("rst_grant",     64'(grant),     64'(2'b00));
    check_eq("rst_s_valid",   64'(s_valid),   64'(1'b0));
    check_eq("rst_m0_rvalid", 64'(m0_rvalid), 64'(1'b0));
    check_eq("rst_m1_rvalid", 64'(m1_rvalid), 64'(1'b0));
    check_eq("rst_m0_wready", 64'(m0_wready), 64'(1'b0));
    check_eq("rst_m1_wready", 64'(m1_wready), 64'(1'b0));
    check_eq("rst_m0_rdata",  64'(m0_rdata),  64'(0));
    check_eq("rst_m1_rdata",  64'(m1_rdata),  64'(0));
    check_eq("rst_m0_err",    64'(m0_err),    64'(1'b0));
    check_eq("rst_m1_err",    64'(m1_err),    64'(1'b0));
    act[0] = 1'b0;
    act[1] = 1'b0;
    drive_masters();
    s_rvalid = 1'b0;
    s_wready = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    n_owner  = -1;
    n_last   = 1;
    n_wcnt   = 0;
    n_err[0] = 1'b0;
    n_err[1] = 1'b0;
    n_rst++;
  endtask

  initial begin
    checks = 0; failures = 0;
    n_tie = 0; n_to = 0; n_done = 0; n_ab = 0; n_rst = 0; n_bound = 0;
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; md[m] = 1'b0; rr[m] = 1'b0; ad[m] = '0; wd[m] = '0;
      err_exp[m] = 1'b0; n_err[m] = 1'b0;
    end
    drive_masters();
    s_wready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    scnt = 0; sdelay = 0; srd = '0;
    owner = -1; last = 1; wcnt = 0;
    n_owner = -1; n_last = 1; n_wcnt = 0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_eq("init_grant",   64'(grant),   64'(2'b00));
    check_eq("init_s_valid", 64'(s_valid), 64'(1'b0));
    check_eq("init_s_addr",  64'(s_addr),  64'(0));
    check_eq("init_s_wdata", 64'(s_wdata), 64'(0));
    check_eq("init_m0_err",  64'(m0_err),  64'(1'b0));
    check_eq("init_m1_err",  64'(m1_err),  64'(1'b0));
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    next_rst = 400;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (owner < 0 && n_owner >= 0) begin
        scnt = 0;
        srd  = $urandom;
        case ($urandom % 8)
          5:       sdelay = 7;
          6:       sdelay = 8;
          7:       sdelay = 30;
          default: sdelay = int'($urandom % 5);
        endcase
      end
      owner   = n_owner;
      last    = n_last;
      wcnt    = n_wcnt;
      err_exp = n_err;

      for (int m = 0; m < 2; m++) begin
        if (!act[m]) begin
          if ($urandom % 2 == 0) begin
            act[m] = 1'b1;
            md[m]  = 1'($urandom);
            ad[m]  = $urandom;
            wd[m]  = $urandom;
          end
        end else if (owner == m && $urandom % 40 == 0) begin
          act[m] = 1'b0;
        end
        rr[m] = ($urandom % 4) != 0;
      end
      drive_masters();

      s_wready = 1'b0;
      s_rvalid = 1'b0;
      s_rdata  = $urandom;
      if (owner < 0) begin
        s_wready = ($urandom % 4) == 0;
        s_rvalid = ($urandom % 4) == 0;
      end else if (act[owner]) begin
        if (scnt >= sdelay) begin
          if (md[owner]) begin
            s_wready = 1'b1;
          end else begin
            s_rvalid = 1'b1;
            s_rdata  = srd;
          end
        end
        scnt++;
      end

      #1;
      check_outputs();
      model_step();
      if (cyc >= next_rst && owner >= 0) begin
        reset_pulse();
        next_rst = cyc + 700;
      end
    end

    check_eq("cov_ties",     64'(n_tie > 0),   64'(1));
    check_eq("cov_timeouts", 64'(n_to > 0),    64'(1));
    check_eq("cov_done",     64'(n_done > 0),  64'(1));
    check_eq("cov_abandon",  64'(n_ab > 0),    64'(1));
    check_eq("cov_resets",   64'(n_rst > 0),   64'(1));
    check_eq("cov_boundary", 64'(n_bound > 0), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
